// File: rtl/spi_cmd_pkg.sv
// Shared definitions for the SPI command controller: the FSM state
// encoding and the fixed protocol constants (RW bit, sync byte).
package spi_cmd_pkg;

    typedef logic [2:0] state_t;

    localparam state_t IDLE     = 3'd0;
    localparam state_t HDR      = 3'd1;
    localparam state_t WDATA    = 3'd2;
    localparam state_t RD_ISSUE = 3'd3;
    localparam state_t RD_WAIT  = 3'd4;
    localparam state_t RD_HOLD  = 3'd5;

    localparam int         RW_BIT    = 7;
    localparam logic [7:0] SYNC_BYTE = 8'hA5;

endpackage

// File: rtl/spi_edge_det.sv
// Registered rise/fall detector for a level that is already synchronous
// to clk.
// Ports: clk, rst_n (sync, active-low), d (level), rise/fall (1-cycle).
module spi_edge_det (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic rise,
    output logic fall
);

    logic q;

    // q resets low, so a level that is already low after reset never
    // produces a fall: the controller waits for a genuine new edge.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            q <= 1'b0;
        end else begin
            q <= d;
        end
    end

    assign rise = d & ~q;
    assign fall = ~d & q;

endmodule

// File: rtl/spi_cmd_ctrl.sv
// Command sequencer behind the SPI byte interface: header byte selects
// write (auto-increment) or streaming read on a simple register bus.
// Ports: m_clk, rst_n, csn_sync, drdy, d_rx in; d_tx, dwritten out;
//        reg_addr, reg_wdata, reg_we, reg_re out; reg_rdata in;
//        busy, ovr out.
module spi_cmd_ctrl #(
    parameter int ADDR_W = 7,
    parameter int BYTE_W = 8
) (
    input  logic              m_clk,
    input  logic              rst_n,
    input  logic              csn_sync,
    input  logic              drdy,
    input  logic [BYTE_W-1:0] d_rx,
    output logic [BYTE_W-1:0] d_tx,
    output logic              dwritten,
    output logic [ADDR_W-1:0] reg_addr,
    output logic [BYTE_W-1:0] reg_wdata,
    output logic              reg_we,
    output logic              reg_re,
    input  logic [BYTE_W-1:0] reg_rdata,
    output logic              busy,
    output logic              ovr
);

    import spi_cmd_pkg::*;

    localparam logic [ADDR_W-1:0] ADDR_ONE = ADDR_W'(1);

    state_t            state;
    logic [ADDR_W-1:0] addr;

    logic byte_ev;
    logic csn_rise;
    logic csn_fall;
    logic unused_drdy_fall;

    logic frame_brk;
    logic hdr_ev;
    logic wr_ev;
    logic rd_done;

    spi_edge_det u_drdy (
        .clk   (m_clk),
        .rst_n (rst_n),
        .d     (drdy),
        .rise  (byte_ev),
        .fall  (unused_drdy_fall)
    );

    spi_edge_det u_csn (
        .clk   (m_clk),
        .rst_n (rst_n),
        .d     (csn_sync),
        .rise  (csn_rise),
        .fall  (csn_fall)
    );

    // Any csn edge overrides the byte-level work of the current cycle,
    // so a byte landing together with the csn rise is dropped.
    always_comb begin
        frame_brk = csn_rise | csn_fall;
        hdr_ev    = (state == HDR) && byte_ev && !frame_brk;
        wr_ev     = (state == WDATA) && byte_ev && !frame_brk;
        rd_done   = (state == RD_WAIT) && !frame_brk;
    end

    // Read strobe is a Moore output of RD_ISSUE so that read data
    // arrives in RD_WAIT and the header-to-dwritten latency is 3.
    assign reg_re = (state == RD_ISSUE);
    assign busy   = (state != IDLE);

    always_ff @(posedge m_clk) begin
        if (!rst_n) begin
            addr <= '0;
        end else if (hdr_ev) begin
            addr <= d_rx[ADDR_W-1:0];
        end else if (wr_ev || rd_done) begin
            addr <= addr + ADDR_ONE;
        end
    end

    always_ff @(posedge m_clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            d_tx      <= '0;
            dwritten  <= 1'b0;
            reg_addr  <= '0;
            reg_wdata <= '0;
            reg_we    <= 1'b0;
            ovr       <= 1'b0;
        end else begin
            dwritten <= 1'b0;
            reg_we   <= 1'b0;
            // A fall outside IDLE behaves as rise+fall: restart a frame.
            if (csn_fall) begin
                state    <= HDR;
                ovr      <= 1'b0;
                d_tx     <= BYTE_W'(SYNC_BYTE);
                dwritten <= 1'b1;
            end else if (csn_rise) begin
                state <= IDLE;
            end else begin
                case (state)
                    IDLE: begin
                    end
                    HDR: begin
                        if (byte_ev) begin
                            reg_addr <= d_rx[ADDR_W-1:0];
                            state    <= d_rx[RW_BIT] ? RD_ISSUE : WDATA;
                        end
                    end
                    WDATA: begin
                        if (byte_ev) begin
                            reg_wdata <= d_rx;
                            reg_addr  <= addr;
                            reg_we    <= 1'b1;
                        end
                    end
                    RD_ISSUE: begin
                        if (byte_ev) ovr <= 1'b1;
                        state <= RD_WAIT;
                    end
                    RD_WAIT: begin
                        if (byte_ev) ovr <= 1'b1;
                        d_tx     <= reg_rdata;
                        dwritten <= 1'b1;
                        // Pre-point the bus at the next streaming address.
                        reg_addr <= addr + ADDR_ONE;
                        state    <= RD_HOLD;
                    end
                    RD_HOLD: begin
                        if (byte_ev) state <= RD_ISSUE;
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_spi_cmd_ctrl.sv
// Scoreboard bench for spi_cmd_ctrl: stimulus pushes expected register
// writes and transmit bytes, a negedge monitor pops and compares them.
module tb_spi_cmd_ctrl;

    logic       m_clk;
    logic       rst_n;
    logic       csn_sync;
    logic       drdy;
    logic [7:0] d_rx;
    logic [7:0] d_tx;
    logic       dwritten;
    logic [6:0] reg_addr;
    logic [7:0] reg_wdata;
    logic       reg_we;
    logic       reg_re;
    logic [7:0] reg_rdata;
    logic       busy;
    logic       ovr;

    typedef struct {
        logic [6:0] a;
        logic [7:0] d;
    } wr_t;

    wr_t        exp_wr[$];
    logic [7:0] exp_tx[$];
    wr_t        e_wr;
    logic [7:0] e_tx;

    int total = 0;
    int bad   = 0;
    int we_cnt = 0;
    int re_cnt = 0;
    int dw_cnt = 0;

    spi_cmd_ctrl dut (
        .m_clk     (m_clk),
        .rst_n     (rst_n),
        .csn_sync  (csn_sync),
        .drdy      (drdy),
        .d_rx      (d_rx),
        .d_tx      (d_tx),
        .dwritten  (dwritten),
        .reg_addr  (reg_addr),
        .reg_wdata (reg_wdata),
        .reg_we    (reg_we),
        .reg_re    (reg_re),
        .reg_rdata (reg_rdata),
        .busy      (busy),
        .ovr       (ovr)
    );

    initial m_clk = 1'b0;
    always #5 m_clk = ~m_clk;

    // Register file model: data = addr + 0x40, one cycle after reg_re.
    initial reg_rdata = 8'h00;
    always @(posedge m_clk) begin
        if (reg_re) reg_rdata <= {1'b0, reg_addr} + 8'h40;
    end

    task automatic check(input string nm, input logic [31:0] got,
                         input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", nm, got, exp);
        end
    endtask

    always @(negedge m_clk) begin
        if (reg_we && reg_re) begin
            total++;
            bad++;
            $display("FAIL we_re_overlap: both strobes high");
        end
        if (reg_re) re_cnt++;
        if (reg_we) begin
            we_cnt++;
            if (exp_wr.size() == 0) begin
                total++;
                bad++;
                $display("FAIL wr_unexp: got addr %0h data %0h want none",
                         reg_addr, reg_wdata);
            end else begin
                e_wr = exp_wr.pop_front();
                check("wr_addr", 32'(reg_addr), 32'(e_wr.a));
                check("wr_data", 32'(reg_wdata), 32'(e_wr.d));
            end
        end
        if (dwritten) begin
            dw_cnt++;
            if (exp_tx.size() == 0) begin
                total++;
                bad++;
                $display("FAIL tx_unexp: got d_tx %0h want none", d_tx);
            end else begin
                e_tx = exp_tx.pop_front();
                check("tx_byte", 32'(d_tx), 32'(e_tx));
            end
        end
    end

    task automatic tick;
        @(negedge m_clk);
    endtask

    task automatic push_wr(input logic [6:0] a, input logic [7:0] d);
        wr_t w;
        w.a = a;
        w.d = d;
        exp_wr.push_back(w);
    endtask

    task automatic send_byte(input logic [7:0] b, input int hold);
        d_rx = b;
        drdy = 1'b1;
        repeat (hold) tick();
        drdy = 1'b0;
        repeat (4) tick();
    endtask

    task automatic start_frame;
        csn_sync = 1'b0;
        exp_tx.push_back(8'hA5);
        tick();
        check("sync_dtx", 32'(d_tx), 32'hA5);
        check("busy_on", 32'(busy), 32'd1);
        tick();
    endtask

    task automatic end_frame;
        csn_sync = 1'b1;
        tick();
        check("busy_off", 32'(busy), 32'd0);
        tick();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "timeout");
    end

    initial begin
        int n;
        int w0;
        int r0;
        int d0;

        rst_n    = 1'b0;
        csn_sync = 1'b1;
        drdy     = 1'b0;
        d_rx     = 8'h85;
        for (int i = 0; i < 3; i++) begin
            drdy = ~drdy;
            tick();
        end
        check("rst_dtx", 32'(d_tx), 32'd0);
        check("rst_dw", 32'(dwritten), 32'd0);
        check("rst_addr", 32'(reg_addr), 32'd0);
        check("rst_wdata", 32'(reg_wdata), 32'd0);
        check("rst_we", 32'(reg_we), 32'd0);
        check("rst_re", 32'(reg_re), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_ovr", 32'(ovr), 32'd0);
        drdy  = 1'b0;
        rst_n = 1'b1;
        repeat (2) tick();

        // Write burst, one byte with drdy held for 3 cycles.
        w0 = we_cnt;
        start_frame();
        send_byte(8'h05, 1);
        push_wr(7'h05, 8'h11);
        send_byte(8'h11, 1);
        push_wr(7'h06, 8'h22);
        send_byte(8'h22, 3);
        push_wr(7'h07, 8'h33);
        send_byte(8'h33, 1);
        end_frame();
        check("wr_cnt", 32'(we_cnt - w0), 32'd3);

        // Streaming read with latency measurement.
        r0 = re_cnt;
        d0 = dw_cnt;
        start_frame();
        exp_tx.push_back(8'h45);
        d_rx = 8'h85;
        drdy = 1'b1;
        n = 0;
        do begin
            tick();
            drdy = 1'b0;
            n++;
        end while (!dwritten && n < 10);
        check("rd_lat", 32'(n), 32'd3);
        check("rd_dtx0", 32'(d_tx), 32'h45);
        repeat (2) tick();
        exp_tx.push_back(8'h46);
        send_byte(8'h00, 1);
        exp_tx.push_back(8'h47);
        send_byte(8'h00, 1);
        end_frame();
        check("rd_re_cnt", 32'(re_cnt - r0), 32'd3);
        check("rd_dw_cnt", 32'(dw_cnt - d0), 32'd4);

        // Address wrap.
        start_frame();
        send_byte(8'h7F, 1);
        push_wr(7'h7F, 8'hAA);
        send_byte(8'hAA, 1);
        push_wr(7'h00, 8'hBB);
        send_byte(8'hBB, 1);
        end_frame();

        // Abort: csn rises together with the 2nd data byte.
        w0 = we_cnt;
        start_frame();
        send_byte(8'h10, 1);
        push_wr(7'h10, 8'h01);
        send_byte(8'h01, 1);
        d_rx     = 8'h02;
        drdy     = 1'b1;
        csn_sync = 1'b1;
        tick();
        check("abort_busy", 32'(busy), 32'd0);
        drdy = 1'b0;
        repeat (3) tick();
        check("abort_we", 32'(we_cnt - w0), 32'd1);
        start_frame();
        send_byte(8'h20, 1);
        push_wr(7'h20, 8'h55);
        send_byte(8'h55, 1);
        end_frame();

        // Overrun: second byte lands while the read is in flight.
        start_frame();
        check("ovr_pre", 32'(ovr), 32'd0);
        exp_tx.push_back(8'h43);
        d_rx = 8'h83;
        drdy = 1'b1;
        tick();
        drdy = 1'b0;
        tick();
        d_rx = 8'h99;
        drdy = 1'b1;
        tick();
        drdy = 1'b0;
        tick();
        check("ovr_set", 32'(ovr), 32'd1);
        repeat (4) tick();
        exp_tx.push_back(8'h44);
        send_byte(8'h00, 1);
        end_frame();
        check("ovr_hold", 32'(ovr), 32'd1);
        csn_sync = 1'b0;
        exp_tx.push_back(8'hA5);
        tick();
        check("ovr_clr", 32'(ovr), 32'd0);
        tick();
        end_frame();

        repeat (5) tick();
        check("wr_q_empty", 32'(exp_wr.size()), 32'd0);
        check("tx_q_empty", 32'(exp_tx.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
